// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte sources, the arbiter and the uart transmitter.
// The arbiter connects through the master modport and the sources/uart side through slave.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic [7:0]           tx_data;
  logic                 tx_data_valid;
  logic                 tx_data_ack;

  modport master (
    input  req_valid, req_data, req_last, tx_data_ack,
    output req_ack, tx_data, tx_data_valid
  );

  modport slave (
    output req_valid, req_data, req_last, tx_data_ack,
    input  req_ack, tx_data, tx_data_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart byte interface among NUM_REQ sources.
// A granted source keeps the uart until its last byte, or until it idles past LOCK_TIMEOUT.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int TO_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.master bus,
  output logic             busy,
  output logic [ID_W-1:0]  grant_id,
  output logic             lock_timeout
);

  typedef enum logic [1:0] {IDLE, SEND, ACK, HOLD} state_t;

  localparam logic [TO_W-1:0] TO_LAST = (LOCK_TIMEOUT == 0) ? '0 : TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt, grant_nxt, next_id;
  logic [7:0]      tx_data_q, data_nxt;
  logic            last_flag, last_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            timeout_nxt;
  logic            found;
  logic [ID_W-1:0] pick;
  logic [7:0]      req_byte [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = bus.req_data[8*i +: 8];
    end
  end

  // First valid requester at or after the priority pointer, wrapping around.
  always_comb begin
    logic [ID_W-1:0] idx;
    found = 1'b0;
    pick  = ptr;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign next_id = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      grant_id     <= '0;
      tx_data_q    <= '0;
      last_flag    <= 1'b0;
      to_cnt       <= '0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      grant_id     <= grant_nxt;
      tx_data_q    <= data_nxt;
      last_flag    <= last_nxt;
      to_cnt       <= to_cnt_nxt;
      lock_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    grant_nxt   = grant_id;
    data_nxt    = tx_data_q;
    last_nxt    = last_flag;
    to_cnt_nxt  = to_cnt;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          data_nxt  = req_byte[pick];
          last_nxt  = bus.req_last[pick];
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (bus.tx_data_ack) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (last_flag) begin
          ptr_nxt   = next_id;
          state_nxt = IDLE;
        end else begin
          to_cnt_nxt = '0;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        // A byte arriving on the expiry cycle still beats the timeout.
        if (bus.req_valid[grant_id]) begin
          data_nxt   = req_byte[grant_id];
          last_nxt   = bus.req_last[grant_id];
          to_cnt_nxt = '0;
          state_nxt  = SEND;
        end else if ((LOCK_TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
          timeout_nxt = 1'b1;
          ptr_nxt     = next_id;
          to_cnt_nxt  = '0;
          state_nxt   = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ack       = '0;
    bus.tx_data       = tx_data_q;
    bus.tx_data_valid = (state == SEND);
    busy              = (state != IDLE);
    if (state == ACK) begin
      bus.req_ack[grant_id] = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued source models, a uart ack model and an ack monitor.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int ID_W         = 2;
  localparam int LOCK_TIMEOUT = 8;
  localparam int TO_W         = 16;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [7:0]      data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            busy;
  logic [ID_W-1:0] grant_id;
  logic            lock_timeout;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W(ID_W),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .TO_W(TO_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy(busy),
    .grant_id(grant_id),
    .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic [8:0] src_q [NUM_REQ][$];
  exp_t sb_q [$];
  int   ack_delay = 0;
  int   to_count = 0;
  int   to_dist = 0;
  int   cyc_since_ack = 0;
  bit   gap_track = 0;
  bit   have_fall = 0;
  int   low_cnt = 0;
  int   gap_n = 0;
  int   gap_min = 1000;
  int   gap_max = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] data, input logic last);
    src_q[id].push_back({last, data});
  endtask

  task automatic expectGrant(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = ID_W'(id);
    e.data = data;
    sb_q.push_back(e);
  endtask

  function automatic bit srcPending();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic clearStats();
    to_count  = 0;
    to_dist   = 0;
    have_fall = 0;
    gap_n     = 0;
    gap_min   = 1000;
    gap_max   = 0;
  endtask

  task automatic flushQueues();
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    sb_q.delete();
  endtask

  task automatic resetDut(input string name);
    #2 rst_n = 1'b0;
    flushQueues();
    repeat (3) @(negedge clk);
    checkOutput({name, "_rst_valid"}, 32'(bus.tx_data_valid), 32'd0);
    checkOutput({name, "_rst_data"}, 32'(bus.tx_data), 32'd0);
    checkOutput({name, "_rst_ack"}, 32'(bus.req_ack), 32'd0);
    checkOutput({name, "_rst_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_rst_grant"}, 32'(grant_id), 32'd0);
    checkOutput({name, "_rst_timeout"}, 32'(lock_timeout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    clearStats();
  endtask

  task automatic waitDone(input string name);
    int cyc = 0;
    while ((sb_q.size() != 0 || srcPending() || busy) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({name, "_drained"}, 32'(cyc < 400), 32'd1);
    checkOutput({name, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Source models: present the head of each queue, retire it once its req_ack was seen.
  initial begin
    logic [NUM_REQ-1:0] acked;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      acked = bus.req_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acked[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (src_q[i].size() != 0) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_data[8*i +: 8] = src_q[i][0][7:0];
          bus.req_last[i]        = src_q[i][0][8];
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_last[i]  = 1'b0;
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.tx_data_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_data_ack) begin
        bus.tx_data_ack = 1'b0;
      end else if (bus.tx_data_valid) begin
        if (wait_cnt >= ack_delay) begin
          bus.tx_data_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    exp_t e;
    bit   prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.req_ack != '0) begin
        cyc_since_ack = 0;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ack: got req_ack 0x%0h, required no ack", bus.req_ack);
        end else begin
          e = sb_q.pop_front();
          checkOutput("ack_vec", 32'(bus.req_ack), 32'd1 << e.id);
          checkOutput("ack_grant", 32'(grant_id), 32'(e.id));
          checkOutput("ack_data", 32'(bus.tx_data), 32'(e.data));
          checkOutput("ack_valid_low", 32'(bus.tx_data_valid), 32'd0);
        end
      end else begin
        cyc_since_ack++;
      end
      if (lock_timeout) begin
        to_count++;
        to_dist = cyc_since_ack;
      end
      if (bus.tx_data_valid) begin
        if (!prev_valid && have_fall && gap_track) begin
          gap_n++;
          if (low_cnt < gap_min) gap_min = low_cnt;
          if (low_cnt > gap_max) gap_max = low_cnt;
        end
      end else begin
        if (prev_valid) begin
          have_fall = 1'b1;
          low_cnt   = 0;
        end
        low_cnt++;
      end
      prev_valid = bus.tx_data_valid;
    end
  end

  initial begin
    int cyc;

    resetDut("t1");
    applyStimulus(2, 8'h41, 1'b1);
    expectGrant(2, 8'h41);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t1_valid", 32'(bus.tx_data_valid), 32'd1);
    checkOutput("t1_data", 32'(bus.tx_data), 32'h41);
    checkOutput("t1_grant", 32'(grant_id), 32'd2);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("t1_ack_pulse", 32'(bus.req_ack), 32'b0100);
    @(negedge clk);
    checkOutput("t1_ack_one_cycle", 32'(bus.req_ack), 32'd0);
    checkOutput("t1_idle", 32'(busy), 32'd0);
    // Pointer now sits at 3, so requester 3 beats requester 0.
    applyStimulus(0, 8'h50, 1'b1);
    applyStimulus(3, 8'h53, 1'b1);
    expectGrant(3, 8'h53);
    expectGrant(0, 8'h50);
    waitDone("t1_ptr");

    resetDut("t2");
    applyStimulus(0, 8'h10, 1'b1);
    applyStimulus(0, 8'h14, 1'b1);
    applyStimulus(1, 8'h21, 1'b1);
    applyStimulus(2, 8'h32, 1'b1);
    applyStimulus(3, 8'h43, 1'b1);
    expectGrant(0, 8'h10);
    expectGrant(1, 8'h21);
    expectGrant(2, 8'h32);
    expectGrant(3, 8'h43);
    expectGrant(0, 8'h14);
    waitDone("t2_rr");

    resetDut("t3");
    gap_track = 1'b1;
    applyStimulus(0, 8'hA1, 1'b0);
    applyStimulus(0, 8'hA2, 1'b0);
    applyStimulus(0, 8'hA3, 1'b1);
    applyStimulus(1, 8'hB1, 1'b1);
    expectGrant(0, 8'hA1);
    expectGrant(0, 8'hA2);
    expectGrant(0, 8'hA3);
    expectGrant(1, 8'hB1);
    waitDone("t3_lock");
    gap_track = 1'b0;
    checkOutput("t3_gap_count", 32'(gap_n), 32'd3);
    checkOutput("t3_gap_min", 32'(gap_min), 32'd2);
    checkOutput("t3_gap_max", 32'(gap_max), 32'd2);

    resetDut("t4");
    applyStimulus(0, 8'hC1, 1'b0);
    applyStimulus(1, 8'hD1, 1'b1);
    expectGrant(0, 8'hC1);
    expectGrant(1, 8'hD1);
    waitDone("t4_timeout");
    checkOutput("t4_timeout_count", 32'(to_count), 32'd1);
    checkOutput("t4_timeout_dist", 32'(to_dist), 32'd9);

    // Pointer is 2 here; requester 0 is the first valid one in the scan.
    clearStats();
    applyStimulus(0, 8'hE1, 1'b0);
    applyStimulus(1, 8'hF1, 1'b1);
    expectGrant(0, 8'hE1);
    expectGrant(0, 8'hE2);
    expectGrant(1, 8'hF1);
    cyc = 0;
    while (!bus.req_ack[0] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("t5_first_ack", 32'(bus.req_ack[0]), 32'd1);
    repeat (7) @(negedge clk);
    applyStimulus(0, 8'hE2, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_send_valid", 32'(bus.tx_data_valid), 32'd1);
    checkOutput("t5_send_data", 32'(bus.tx_data), 32'hE2);
    checkOutput("t5_no_pulse", 32'(lock_timeout), 32'd0);
    waitDone("t5_boundary");
    checkOutput("t5_timeout_count", 32'(to_count), 32'd0);

    ack_delay = 5;
    applyStimulus(2, 8'h77, 1'b1);
    cyc = 0;
    while (!bus.tx_data_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("t6_in_send", 32'(bus.tx_data_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", 32'(bus.tx_data_valid), 32'd0);
    checkOutput("t6_async_busy", 32'(busy), 32'd0);
    checkOutput("t6_async_ack", 32'(bus.req_ack), 32'd0);
    checkOutput("t6_async_grant", 32'(grant_id), 32'd0);
    flushQueues();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    @(negedge clk);
    applyStimulus(3, 8'h93, 1'b1);
    applyStimulus(0, 8'h90, 1'b1);
    expectGrant(0, 8'h90);
    expectGrant(3, 8'h93);
    waitDone("t6_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
